// File: rtl/key_cnt_pkg.sv
// key_cnt_pkg: shared BCD digit type, timer-width and packed-channel helpers, pure BCD step arithmetic.
package key_cnt_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  function automatic int cnt_width(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
  function automatic int ch_base(input int k, input int digits);
    return k * digits * 4;
  endfunction
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  // Digit-serial ripple: carry/borrow propagates only through the low `digits` digits.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up, input int digits);
    logic [15:0] r;
    logic c;
    bcd_digit_t d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[i*4+:4];
      if (i < digits && c) begin
        c = up ? d == BCD_MAX : d == 4'd0;
        r[i*4+:4] = up ? (c ? 4'd0 : d + 4'd1) : (c ? BCD_MAX : d - 4'd1);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: 2-FF sync, debounce and press strobe for one key; auto-repeat when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
  import key_cnt_pkg::*;
#(
  parameter int DB_CYCLES     = 1_500_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic pulse
);
  localparam int DW = cnt_width(DB_CYCLES);
  logic s0, s1, db_done, press, step;
  logic [DW-1:0] db_cnt;
  assign db_done = db_cnt == DW'(DB_CYCLES - 1);
  assign press = s1 && !level && db_done;
`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  logic [RW-1:0] rep_cnt;
  logic first, rep;
  assign rep = level && (first ? rep_cnt == RW'(REPEAT_DELAY - 1) : rep_cnt == RW'(REPEAT_PERIOD - 1));
  assign step = press || rep;
  // Timer idles at zero while released, so it starts fresh at every press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rep_cnt <= '0;
      first <= 1'b1;
    end else begin
      rep_cnt <= (!level || rep) ? '0 : rep_cnt + 1'b1;
      first <= !level ? 1'b1 : rep ? 1'b0 : first;
    end
  end
`else
  assign step = press;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      level <= 1'b0;
      pulse <= 1'b0;
      db_cnt <= '0;
    end else begin
      s0 <= key;
      s1 <= s0;
      pulse <= step;
      db_cnt <= (s1 == level || db_done) ? '0 : db_cnt + 1'b1;
      level <= (s1 != level && db_done) ? s1 : level;
    end
  end
endmodule

// File: rtl/multi_key_bcd_counter.sv
// multi_key_bcd_counter: N debounced key channels, each driving an up/down BCD counter with wrap or saturate.
// Optional auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
module multi_key_bcd_counter
  import key_cnt_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int DB_CYCLES     = 1_500_000,
  parameter int DIGITS        = 2,
  parameter int MODULUS       = 100,
  parameter int WRAP          = 1,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_KEYS-1:0]        key_in,
  input  logic [NUM_KEYS-1:0]        dir,
  input  logic [NUM_KEYS-1:0]        clr,
  output logic [NUM_KEYS-1:0]        key_level,
  output logic [NUM_KEYS-1:0]        key_pulse,
  output logic [NUM_KEYS-1:0]        wrap_pulse,
  output logic [NUM_KEYS*DIGITS*4-1:0] bcd_out
);
  localparam int W = DIGITS * 4;
  localparam logic [W-1:0] TOP = W'(to_bcd(MODULUS - 1));
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    logic [W-1:0] cnt, nxt_up, nxt_dn;
    logic at_limit, wrap_r;
    key_debounce_ch #(
      .DB_CYCLES(DB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_db (
      .clk(clk),
      .rst(rst),
      .key(key_in[k]),
      .level(key_level[k]),
      .pulse(key_pulse[k])
    );
    assign nxt_up = W'(bcd_step(16'(cnt), 1'b1, DIGITS));
    assign nxt_dn = W'(bcd_step(16'(cnt), 1'b0, DIGITS));
    assign at_limit = dir[k] ? cnt == TOP : cnt == '0;
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt <= '0;
        wrap_r <= 1'b0;
      end else begin
        cnt <= clr[k] ? '0 : !key_pulse[k] ? cnt : !at_limit ? (dir[k] ? nxt_up : nxt_dn) :
               WRAP == 0 ? cnt : dir[k] ? '0 : TOP;
        wrap_r <= !clr[k] && key_pulse[k] && at_limit;
      end
    end
    assign wrap_pulse[k] = wrap_r;
    assign bcd_out[ch_base(k, DIGITS) +: W] = cnt;
  end
endmodule

// File: tb/tb_multi_key_bcd_counter.sv
// tb_multi_key_bcd_counter: directed checks of debounce latency, bounce rejection, BCD wrap/borrow, clr priority and repeat.
module tb_multi_key_bcd_counter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] key_in, dir, clr, key_level, key_pulse, wrap_pulse;
  logic [31:0] bcd_out;
  int n_vec = 0, n_err = 0;
  int pc[4], wc[4];
`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_EXP = 6;
`else
  localparam int REP_EXP = 1;
`endif

  multi_key_bcd_counter #(
    .NUM_KEYS(4), .DB_CYCLES(4), .DIGITS(2), .MODULUS(100), .WRAP(1),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .dir(dir), .clr(clr),
    .key_level(key_level), .key_pulse(key_pulse), .wrap_pulse(wrap_pulse), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      pc[k] += int'(key_pulse[k]);
      wc[k] += int'(wrap_pulse[k]);
    end
  endtask

  task automatic clear_counts;
    for (int k = 0; k < 4; k++) begin
      pc[k] = 0;
      wc[k] = 0;
    end
  endtask

  task automatic press(input logic [3:0] m);
    key_in = key_in | m;
    repeat (10) tick();
    key_in = key_in & ~m;
    repeat (10) tick();
  endtask

  task automatic test_reset;
    int c;
    rst = 1'b0;
    key_in = 4'hF;
    repeat (3) tick();
    n_vec++; if (key_level !== 4'h0) begin n_err++; $display("FAIL reset_level got %h exp 0", key_level); end
    n_vec++; if (key_pulse !== 4'h0) begin n_err++; $display("FAIL reset_pulse got %h exp 0", key_pulse); end
    n_vec++; if (wrap_pulse !== 4'h0) begin n_err++; $display("FAIL reset_wrap got %h exp 0", wrap_pulse); end
    n_vec++; if (bcd_out !== 32'h0) begin n_err++; $display("FAIL reset_bcd got %h exp 0", bcd_out); end
    rst = 1'b1;
    for (c = 1; c <= 12; c++) begin
      tick();
      if (key_level[0]) break;
    end
    n_vec++; if (c != 6) begin n_err++; $display("FAIL level_latency got %0d exp 6", c); end
    n_vec++; if (key_pulse !== 4'hF) begin n_err++; $display("FAIL press_pulse got %h exp f", key_pulse); end
    tick();
    n_vec++; if (bcd_out !== 32'h01010101) begin n_err++; $display("FAIL first_count got %h exp 01010101", bcd_out); end
    clear_counts();
    key_in = 4'h0;
    repeat (10) tick();
    n_vec++; if (pc[0] + pc[1] + pc[2] + pc[3] != 0) begin n_err++; $display("FAIL release_pulse got %0d exp 0", pc[0] + pc[1] + pc[2] + pc[3]); end
    clr = 4'hF;
    tick();
    clr = 4'h0;
    tick();
    n_vec++; if (bcd_out !== 32'h0 || key_level !== 4'h0) begin n_err++; $display("FAIL clr_all got %h/%h exp 0/0", bcd_out, key_level); end
  endtask

  task automatic test_bounce;
    clear_counts();
    repeat (3) begin
      key_in[0] = 1'b1;
      repeat (3) tick();
      key_in[0] = 1'b0;
      repeat (3) tick();
    end
    repeat (5) tick();
    n_vec++; if (pc[0] != 0 || key_level[0] !== 1'b0) begin n_err++; $display("FAIL glitch got pulses=%0d level=%b exp 0/0", pc[0], key_level[0]); end
    press(4'h1);
    n_vec++; if (pc[0] != 1) begin n_err++; $display("FAIL hold_pulse got %0d exp 1", pc[0]); end
    n_vec++; if (bcd_out[7:0] !== 8'h01) begin n_err++; $display("FAIL hold_count got %h exp 01", bcd_out[7:0]); end
  endtask

  task automatic test_wrap;
    clear_counts();
    repeat (99) press(4'h2);
    n_vec++; if (bcd_out[15:8] !== 8'h99 || wc[1] != 0) begin n_err++; $display("FAIL preset99 got %h wraps=%0d exp 99/0", bcd_out[15:8], wc[1]); end
    press(4'h2);
    n_vec++; if (bcd_out[15:8] !== 8'h00) begin n_err++; $display("FAIL wrap_up got %h exp 00", bcd_out[15:8]); end
    n_vec++; if (wc[1] != 1) begin n_err++; $display("FAIL wrap_up_pulse got %0d exp 1", wc[1]); end
  endtask

  task automatic test_down;
    clear_counts();
    repeat (10) press(4'h4);
    n_vec++; if (bcd_out[23:16] !== 8'h10) begin n_err++; $display("FAIL up_to10 got %h exp 10", bcd_out[23:16]); end
    dir[2] = 1'b0;
    press(4'h4);
    n_vec++; if (bcd_out[23:16] !== 8'h09) begin n_err++; $display("FAIL borrow got %h exp 09", bcd_out[23:16]); end
    repeat (9) press(4'h4);
    n_vec++; if (bcd_out[23:16] !== 8'h00 || wc[2] != 0) begin n_err++; $display("FAIL down_to0 got %h wraps=%0d exp 00/0", bcd_out[23:16], wc[2]); end
    press(4'h4);
    n_vec++; if (bcd_out[23:16] !== 8'h99 || wc[2] != 1) begin n_err++; $display("FAIL wrap_down got %h wraps=%0d exp 99/1", bcd_out[23:16], wc[2]); end
    dir[2] = 1'b1;
  endtask

  task automatic test_priority;
    bit found;
    clear_counts();
    found = 1'b0;
    dir[3] = 1'b0;
    key_in[3] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (key_pulse[3]) begin found = 1'b1; break; end
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL ch3_pulse got none exp 1 within 15 cycles"); end
    clr[3] = 1'b1;
    tick();
    clr[3] = 1'b0;
    tick();
    n_vec++; if (bcd_out[31:24] !== 8'h00 || wc[3] != 0) begin n_err++; $display("FAIL clr_priority got %h wraps=%0d exp 00/0", bcd_out[31:24], wc[3]); end
    key_in[3] = 1'b0;
    repeat (10) tick();
    dir = 4'hF;
  endtask

  task automatic test_all_keys;
    clear_counts();
    press(4'hF);
    n_vec++; if (pc[0] != 1 || pc[1] != 1 || pc[2] != 1 || pc[3] != 1) begin n_err++; $display("FAIL all_pulses got %0d%0d%0d%0d exp 1111", pc[3], pc[2], pc[1], pc[0]); end
    n_vec++; if (bcd_out !== 32'h01000102) begin n_err++; $display("FAIL all_count got %h exp 01000102", bcd_out); end
    n_vec++; if (wc[2] != 1 || wc[0] + wc[1] + wc[3] != 0) begin n_err++; $display("FAIL all_wrap got %0d/%0d exp 1/0", wc[2], wc[0] + wc[1] + wc[3]); end
  endtask

  task automatic test_autorepeat;
    bit found;
    clear_counts();
    found = 1'b0;
    key_in[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (pc[0] > 0) begin found = 1'b1; break; end
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rep_press got none exp pulse within 15 cycles"); end
    repeat (37) tick();
    key_in[0] = 1'b0;
    repeat (3) tick();
    n_vec++; if (pc[0] != REP_EXP) begin n_err++; $display("FAIL rep_count got %0d exp %0d", pc[0], REP_EXP); end
    repeat (10) tick();
    n_vec++; if (pc[0] != REP_EXP || key_level[0] !== 1'b0) begin n_err++; $display("FAIL rep_release got %0d/%b exp %0d/0", pc[0], key_level[0], REP_EXP); end
    n_vec++; if (bcd_out[7:0] !== {4'(((2 + REP_EXP) / 10)), 4'(((2 + REP_EXP) % 10))}) begin n_err++; $display("FAIL rep_bcd got %h exp %0d", bcd_out[7:0], 2 + REP_EXP); end
  endtask

  initial begin
    rst = 1'b0;
    key_in = 4'h0;
    dir = 4'hF;
    clr = 4'h0;
    clear_counts();
    test_reset();
    test_bounce();
    test_wrap();
    test_down();
    test_priority();
    test_all_keys();
    test_autorepeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
